instr_cache_l1_assoc: RTL and testbench

Parametrised, set-associative L1 instruction cache sitting between the IF stage and the L2/memory refill port. It is the successor to the direct-mapped L1 I-cache and generalises line size, set count and associativity (1 or 2 ways, LRU). It replaces counter-timed refill with a real request/valid handshake and adds a flush input and hit/miss performance counters. Lookup is combinational. A miss triggers one full-line refill and then a replay.

---
 rtl/instr_cache_l1_assoc.sv | 193 +++++++++++++++++++
 tb/tb_instr_cache_l1_assoc.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_cache_l1_assoc.sv
`timescale 1ns/1ps
// instr_cache_l1_assoc
// Set-associative (1 or 2 ways) L1 instruction cache. Lookup is combinational.
// A miss starts one full-line refill over a request/valid handshake. The cache
// then installs the line and replays the lookup. Also has a flush input and
// saturating hit/miss counters.
module instr_cache_l1_assoc #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int SETS       = 256,
    parameter int WAYS       = 2
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [ADDR_W-1:0]       instr_addressIF,
    input  logic                    flush,
    output logic [31:0]             instr_out,
    output logic                    hit,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_address,
    input  logic [32*LINE_WORDS-1:0] mem_data,
    input  logic                    mem_valid,
    output logic [31:0]             hit_count,
    output logic [31:0]             miss_count
);
    localparam int LINE_W = 32 * LINE_WORDS;
    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
    localparam int WRD_W  = OFF_W - 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FILL = 2'd2;

    logic [1:0]              state_q, state_d;
    logic                    mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
    logic [ADDR_W-OFF_W-1:0] miss_line_q, miss_line_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic                    discard_q, discard_d;
    logic [SETS-1:0]         valid_q [WAYS];
    logic [SETS-1:0]         valid_d [WAYS];
    logic [SETS-1:0]         lru_q, lru_d;
    logic [31:0]             hit_cnt_q, hit_cnt_d;
    logic [31:0]             miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]        tag_mem  [WAYS][SETS];
    logic [LINE_W-1:0]       data_mem [WAYS][SETS];

    // Lookup address fields; the byte-within-word bits play no part in a fetch
    logic [TAG_W-1:0]        lk_tag;
    logic [IDX_W-1:0]        lk_idx;
    logic [WRD_W-1:0]        lk_word;
    logic                    unused_byte;

    assign lk_tag      = instr_addressIF[ADDR_W-1 -: TAG_W];
    assign lk_idx      = instr_addressIF[OFF_W +: IDX_W];
    assign lk_word     = instr_addressIF[2 +: WRD_W];
    assign unused_byte = ^instr_addressIF[1:0];

    logic [WAYS-1:0]         way_hit;
    logic [31:0]             way_word [WAYS];

    // Per-way tag compare and word select (word 0 sits in the line MSBs, so the
    // bit offset of word k is 32 * (LINE_WORDS-1-k) = {~k, 5'b0})
    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [LINE_W-1:0] rd_line;
        assign rd_line      = data_mem[gi][lk_idx];
        assign way_hit[gi]  = valid_q[gi][lk_idx] && (tag_mem[gi][lk_idx] == lk_tag);
        assign way_word[gi] = rd_line[{~lk_word, 5'b00000} +: 32];
    end

    logic hit_way;
    logic lookup_hit;

    assign hit_way    = (WAYS > 1) ? ~way_hit[0] : 1'b0;
    assign lookup_hit = |way_hit;
    assign hit        = lookup_hit && (state_q == ST_IDLE) && !flush;
    assign instr_out  = hit ? way_word[hit_way] : 32'd0;

    // Refill target: set and tag come from the latched miss line
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             victim;
    logic             fill_we;

    assign fill_idx = miss_line_q[IDX_W-1:0];
    assign fill_tag = miss_line_q[IDX_W +: TAG_W];
    // A flush in the fill cycle wins over the install
    assign fill_we  = (state_q == ST_FILL) && !discard_q && !flush;

    // Victim: first invalid way (way0 first), otherwise the LRU way
    always_comb begin
        victim = 1'b0;
        if (WAYS > 1 && valid_q[0][fill_idx]) begin
            victim = valid_q[WAYS-1][fill_idx] ? lru_q[fill_idx] : 1'b1;
        end
    end

    // Next-state logic for the refill FSM, valid/LRU bits and counters
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        miss_line_d = miss_line_q;
        line_d      = line_q;
        discard_d   = discard_q;
        valid_d     = valid_q;
        lru_d       = lru_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
                    if (WAYS > 1) lru_d[lk_idx] = ~hit_way;
                end else if (!flush) begin
                    miss_line_d = instr_addressIF[ADDR_W-1:OFF_W];
                    mem_req_d   = 1'b1;
                    mem_addr_d  = {instr_addressIF[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                // The request stays up until the line arrives; a flush only
                // marks the returning line as stale
                if (flush) discard_d = 1'b1;
                if (mem_valid) begin
                    line_d     = mem_data;
                    mem_req_d  = 1'b0;
                    mem_addr_d = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                if (fill_we) begin
                    valid_d[victim][fill_idx] = 1'b1;
                    if (WAYS > 1) lru_d[fill_idx] = ~victim;
                end
                discard_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            for (int w = 0; w < WAYS; w++) valid_d[w] = '0;
            lru_d = '0;
        end
    end

    // Control and status registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            miss_line_q <= '0;
            line_q      <= '0;
            discard_q   <= 1'b0;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
            lru_q       <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            miss_line_q <= miss_line_d;
            line_q      <= line_d;
            discard_q   <= discard_d;
            for (int w = 0; w < WAYS; w++) valid_q[w] <= valid_d[w];
            lru_q       <= lru_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Install the refilled line into the victim way (tag/data arrays carry no reset)
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            tag_mem[victim][fill_idx]  <= fill_tag;
            data_mem[victim][fill_idx] <= line_q;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_address = mem_addr_q;
    assign hit_count   = hit_cnt_q;
    assign miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_instr_cache_l1_assoc.sv
`timescale 1ns/1ps
// Testbench for instr_cache_l1_assoc: directed vector table, hand-written
// multi-cycle sequences (flush, reset, saturation) and a randomized run
// checked against a recency-list model of the cache.
module tb_instr_cache_l1_assoc;
    localparam int LW     = 8;
    localparam int LINE_W = 32 * LW;
    localparam int SETS   = 256;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic [31:0]       fetch_addr = '0;
    logic              flush = 1'b0;
    logic [31:0]       instr_out;
    logic              hit;
    logic              mem_req;
    logic [31:0]       mem_address;
    logic [LINE_W-1:0] mem_data = '0;
    logic              mem_valid = 1'b0;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;

    int n_checks = 0;
    int n_err    = 0;

    instr_cache_l1_assoc #(.ADDR_W(32), .LINE_WORDS(LW), .SETS(SETS), .WAYS(2)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .instr_addressIF (fetch_addr),
        .flush           (flush),
        .instr_out       (instr_out),
        .hit             (hit),
        .mem_req         (mem_req),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_valid       (mem_valid),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1);
    end

    // Backing memory image: one planted word, the rest a hash of the address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (w == 32'h0000_1004) return 32'hDEAD_BEEF;
        return (w * 32'h9E37_79B1) ^ 32'hC3C3_3C3C;
    endfunction

    function automatic logic [LINE_W-1:0] line_data(input logic [31:0] line_addr);
        logic [LINE_W-1:0] l;
        l = '0;
        for (int k = 0; k < LW; k++) l[LINE_W-1-32*k -: 32] = word_at(line_addr + 32'(4*k));
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic f, input logic v, input logic [31:0] ml);
        fetch_addr = a;
        flush      = f;
        mem_valid  = v;
        mem_data   = v ? line_data(ml) : '0;
    endtask

    task automatic cyc(input logic [31:0] a, input logic f, input logic v, input logic [31:0] ml);
        drive(a, f, v, ml);
        @(negedge CLK);
        $display("cycle addr=%08h flush=%0b mv=%0b hit=%0b instr=%08h req=%0b maddr=%08h hc=%0d mc=%0d",
                 a, f, v, hit, instr_out, mem_req, mem_address, hit_count, miss_count);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        drive(32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
    endtask

    // Directed vector table
    typedef struct {
        logic [31:0] addr;
        logic        mv;
        logic [31:0] mline;
        logic        exp_hit;
        logic [31:0] exp_instr;
        logic        exp_req;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vec[$];

    function automatic vec_t mk(input logic [31:0] a, input logic v, input logic [31:0] ml,
                                input logic eh, input logic [31:0] ei, input logic er,
                                input logic [31:0] em);
        vec_t t;
        t.addr = a; t.mv = v; t.mline = ml;
        t.exp_hit = eh; t.exp_instr = ei; t.exp_req = er; t.exp_maddr = em;
        return t;
    endfunction

    // Reference model: per set, resident line addresses ordered most recent first
    typedef enum {P_IDLE, P_REQ, P_FILL} phase_t;
    logic [31:0] m_line [SETS][2];
    int          m_cnt  [SETS];
    phase_t      m_phase;
    logic        m_discard;
    logic [31:0] m_miss;
    logic [31:0] m_hits, m_misses;

    function automatic int set_of(input logic [31:0] a);
        return int'(a[12:5]);
    endfunction

    function automatic bit m_resident(input logic [31:0] a);
        int s;
        s = set_of(a);
        for (int i = 0; i < m_cnt[s]; i++)
            if (m_line[s][i] == {a[31:5], 5'b0}) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_touch(input logic [31:0] a);
        int s;
        logic [31:0] t;
        s = set_of(a);
        if (m_cnt[s] == 2 && m_line[s][1] == {a[31:5], 5'b0}) begin
            t = m_line[s][0];
            m_line[s][0] = m_line[s][1];
            m_line[s][1] = t;
        end
    endtask

    task automatic m_install(input logic [31:0] l);
        int s;
        s = set_of(l);
        m_line[s][1] = m_line[s][0];
        m_line[s][0] = l;
        if (m_cnt[s] < 2) m_cnt[s]++;
    endtask

    task automatic m_reset();
        for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
        m_phase = P_IDLE; m_discard = 1'b0; m_miss = '0; m_hits = '0; m_misses = '0;
    endtask

    task automatic m_step(input logic [31:0] a, input logic f, input logic v);
        case (m_phase)
            P_IDLE: if (!f) begin
                if (m_resident(a)) begin
                    m_touch(a);
                    m_hits++;
                end else begin
                    m_misses++;
                    m_miss  = {a[31:5], 5'b0};
                    m_phase = P_REQ;
                end
            end
            P_REQ: begin
                if (f) m_discard = 1'b1;
                if (v) begin
                    $display("refill line=%08h discard=%0b", m_miss, m_discard | f);
                    m_phase = P_FILL;
                end
            end
            P_FILL: begin
                if (!f && !m_discard) m_install(m_miss);
                m_discard = 1'b0;
                m_phase   = P_IDLE;
            end
            default: m_phase = P_IDLE;
        endcase
        if (f) for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
    endtask

    initial begin
        // ---- reset state ----
        do_reset();
        RESET = 1'b0;
        @(negedge CLK);
        check("rst_hit",   32'(hit), 32'd0);
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_maddr", mem_address, 32'd0);
        check("rst_hc",    hit_count, 32'd0);
        check("rst_mc",    miss_count, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;

        // ---- directed table: cold miss, 2-way conflict/LRU, address change in REQ ----
        vec.push_back(mk(32'h0000_1004, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0000_1004, 0, 0, 0, 32'h0, 1, 32'h0000_1000));
        vec.push_back(mk(32'h0000_1004, 1, 32'h0000_1000, 0, 32'h0, 1, 32'h0000_1000));
        vec.push_back(mk(32'h0000_1004, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0000_1004, 0, 0, 1, 32'hDEAD_BEEF, 0, 32'h0));
        vec.push_back(mk(32'h0010_1000, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0010_1000, 0, 0, 0, 32'h0, 1, 32'h0010_1000));
        vec.push_back(mk(32'h0010_1000, 1, 32'h0010_1000, 0, 32'h0, 1, 32'h0010_1000));
        vec.push_back(mk(32'h0010_1000, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0010_1000, 0, 0, 1, word_at(32'h0010_1000), 0, 32'h0));
        vec.push_back(mk(32'h0000_1000, 0, 0, 1, word_at(32'h0000_1000), 0, 32'h0));
        vec.push_back(mk(32'h0020_1000, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0020_1000, 0, 0, 0, 32'h0, 1, 32'h0020_1000));
        vec.push_back(mk(32'h0020_1000, 1, 32'h0020_1000, 0, 32'h0, 1, 32'h0020_1000));
        vec.push_back(mk(32'h0020_1000, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0020_1000, 0, 0, 1, word_at(32'h0020_1000), 0, 32'h0));
        vec.push_back(mk(32'h0000_1008, 0, 0, 1, word_at(32'h0000_1008), 0, 32'h0));
        vec.push_back(mk(32'h0010_1004, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0000_0200, 0, 0, 0, 32'h0, 1, 32'h0010_1000));
        vec.push_back(mk(32'h0000_0200, 1, 32'h0010_1000, 0, 32'h0, 1, 32'h0010_1000));
        vec.push_back(mk(32'h0000_0200, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0000_0200, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0000_0204, 0, 0, 0, 32'h0, 1, 32'h0000_0200));
        vec.push_back(mk(32'h0000_0204, 1, 32'h0000_0200, 0, 32'h0, 1, 32'h0000_0200));
        vec.push_back(mk(32'h0000_0208, 0, 0, 0, 32'h0, 0, 32'h0));
        vec.push_back(mk(32'h0010_101C, 0, 0, 1, word_at(32'h0010_101C), 0, 32'h0));
        vec.push_back(mk(32'h0000_0200, 0, 0, 1, word_at(32'h0000_0200), 0, 32'h0));

        foreach (vec[i]) begin
            cyc(vec[i].addr, 1'b0, vec[i].mv, vec[i].mline);
            check($sformatf("v%0d_hit", i),   32'(hit), 32'(vec[i].exp_hit));
            check($sformatf("v%0d_instr", i), instr_out, vec[i].exp_instr);
            check($sformatf("v%0d_req", i),   32'(mem_req), 32'(vec[i].exp_req));
            check($sformatf("v%0d_maddr", i), mem_address, vec[i].exp_maddr);
            tick();
        end
        cyc(32'h0000_0200, 0, 0, 0);
        check("table_hc", hit_count, 32'd7);
        check("table_mc", miss_count, 32'd5);
        tick();

        // ---- flush during REQ discards the returning line ----
        cyc(32'h0000_4000, 0, 0, 0); check("fl_miss_hit", 32'(hit), 32'd0); tick();
        cyc(32'h0000_4000, 0, 0, 0); check("fl_req", 32'(mem_req), 32'd1);
        check("fl_maddr", mem_address, 32'h0000_4000); tick();
        cyc(32'h0000_4000, 1, 0, 0); check("fl_req_held", 32'(mem_req), 32'd1);
        check("fl_hit0", 32'(hit), 32'd0); tick();
        cyc(32'h0000_4000, 0, 1, 32'h0000_4000); check("fl_req_mv", 32'(mem_req), 32'd1); tick();
        cyc(32'h0000_4000, 0, 0, 0); check("fl_fill_req", 32'(mem_req), 32'd0);
        check("fl_fill_maddr", mem_address, 32'd0); tick();
        cyc(32'h0000_4000, 0, 0, 0); check("fl_refetch_hit", 32'(hit), 32'd0); tick();
        cyc(32'h0000_4000, 0, 0, 0); check("fl_refetch_req", 32'(mem_req), 32'd1);
        check("fl_refetch_maddr", mem_address, 32'h0000_4000); tick();
        cyc(32'h0000_4000, 0, 1, 32'h0000_4000); tick();
        cyc(32'h0000_4000, 0, 0, 0); tick();
        cyc(32'h0000_4004, 0, 0, 0); check("fl_after_hit", 32'(hit), 32'd1);
        check("fl_after_instr", instr_out, word_at(32'h0000_4004)); tick();
        // flush while idle: hit suppressed this cycle, line gone afterwards
        cyc(32'h0000_4004, 1, 0, 0); check("fli_hit", 32'(hit), 32'd0);
        check("fli_instr", instr_out, 32'd0); tick();
        cyc(32'h0000_4004, 0, 0, 0); check("fli_gone", 32'(hit), 32'd0); tick();
        cyc(32'h0000_4004, 0, 0, 0); check("fli_req", 32'(mem_req), 32'd1); tick();
        cyc(32'h0000_4004, 0, 1, 32'h0000_4000); tick();
        cyc(32'h0000_4004, 0, 0, 0); tick();

        // ---- reset in the middle of a refill ----
        cyc(32'h0000_8000, 0, 0, 0); tick();
        cyc(32'h0000_8000, 0, 0, 0); check("rm_req", 32'(mem_req), 32'd1);
        #2;
        RESET = 1'b0;
        #1;
        check("rm_async_req", 32'(mem_req), 32'd0);
        check("rm_async_maddr", mem_address, 32'd0);
        check("rm_async_hc", hit_count, 32'd0);
        check("rm_async_mc", miss_count, 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        cyc(32'h0000_8000, 0, 1, 32'h0000_8000); check("rm_stray_hit", 32'(hit), 32'd0); tick();
        cyc(32'h0000_8000, 0, 0, 0); check("rm_miss_req", 32'(mem_req), 32'd1);
        check("rm_miss_maddr", mem_address, 32'h0000_8000);
        check("rm_miss_mc", miss_count, 32'd1); tick();
        cyc(32'h0000_8000, 0, 1, 32'h0000_8000); tick();
        cyc(32'h0000_8000, 0, 0, 0); tick();
        cyc(32'h0000_800C, 0, 0, 0); check("rm_hit", 32'(hit), 32'd1);
        check("rm_instr", instr_out, word_at(32'h0000_800C)); tick();

        // ---- hit counter and saturation ----
        do_reset();
        cyc(32'h0000_1000, 0, 0, 0); tick();
        cyc(32'h0000_1000, 0, 0, 0); tick();
        cyc(32'h0000_1000, 0, 1, 32'h0000_1000); tick();
        cyc(32'h0000_1000, 0, 0, 0); tick();
        for (int i = 0; i < 10; i++) begin
            cyc(32'h0000_1000 + 32'(4 * (i % 8)), 0, 0, 0);
            tick();
        end
        cyc(32'h0000_1000, 0, 0, 0);
        check("hc_ten", hit_count, 32'd10);
        check("hc_mc", miss_count, 32'd1);
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.hit_cnt_q;
        cyc(32'h0000_1000, 0, 0, 0);
        check("hc_preload", hit_count, 32'hFFFF_FFFF);
        tick();
        for (int i = 0; i < 3; i++) begin
            cyc(32'h0000_1004, 0, 0, 0);
            tick();
        end
        cyc(32'h0000_1000, 0, 0, 0);
        check("hc_sat_hit", 32'(hit), 32'd1);
        check("hc_sat", hit_count, 32'hFFFF_FFFF);
        check("hc_sat_mc", miss_count, 32'd1);
        tick();

        // ---- randomized run against the reference model ----
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [31:0] a;
            logic        f, v;
            logic        e_hit;
            a = (32'($urandom_range(1, 3)) << 13) | (32'($urandom_range(3, 4)) << 5)
              | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            f = ($urandom_range(0, 24) == 0);
            fetch_addr = a;
            flush      = f;
            if (m_phase == P_REQ) begin
                v = ($urandom_range(0, 2) == 0);
                mem_data = line_data(m_miss);
            end else begin
                v = ($urandom_range(0, 7) == 0);
                mem_data = {8{$urandom}};
            end
            mem_valid = v;
            @(negedge CLK);
            e_hit = (m_phase == P_IDLE) && !f && m_resident(a);
            check("rnd_hit",   32'(hit), 32'(e_hit));
            check("rnd_instr", instr_out, e_hit ? word_at(a) : 32'd0);
            check("rnd_req",   32'(mem_req), 32'(m_phase == P_REQ));
            check("rnd_maddr", mem_address, (m_phase == P_REQ) ? m_miss : 32'd0);
            check("rnd_hc",    hit_count, m_hits);
            check("rnd_mc",    miss_count, m_misses);
            m_step(a, f, v);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
